gram_scheduler: RTL

- Sequences one shared inner-product unit to build the M×M Gram matrix G[i][j] = <v_i, v_j> of M stored column vectors, the first step of the pseudoinverse (AᵀA).
- Selects the vector pair, pulses the unit's start, waits for its end flag, and writes each result into a result memory.
- Symmetric mode computes only the upper triangle and writes each off-diagonal result twice (mirror).

---
 rtl/gram_scheduler_pkg.sv | 29 ++
 rtl/gram_scheduler_index_counter.sv | 54 +++++
 rtl/gram_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gram_scheduler_pkg.sv
// rtl/gram_scheduler_pkg.sv - shared state encoding and helpers for the Gram-matrix scheduler
package gram_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_MIRROR = 3'd4,
    ST_NEXT   = 3'd5,
    ST_FIN    = 3'd6
  } state_e;

  localparam logic IP_ADD = 1'b1;

  // Ceiling log2, never below 1 so single-entry widths stay legal.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gram_scheduler_index_counter.sv
// rtl/gram_scheduler_index_counter.sv - nested i/j pair counter, full or upper-triangle order
module gram_index_counter
  import gram_scheduler_pkg::*;
#(
  parameter int M    = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  logic            sym,
  output logic [IDXW-1:0] i,
  output logic [IDXW-1:0] j,
  output logic            last
);

  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(M - 1);

  logic [IDXW-1:0] i_q, i_d;
  logic [IDXW-1:0] j_q, j_d;

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == MAX_IDX) && (j_q == MAX_IDX);

  // The end-of-row test comes before any increment, so neither index wraps.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      i_d = '0;
      j_d = '0;
    end else if (advance && !last) begin
      if (j_q == MAX_IDX) begin
        i_d = i_q + 1'b1;
        j_d = sym ? (i_q + 1'b1) : '0;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/gram_scheduler.sv
// rtl/gram_scheduler.sv - sequences one inner-product unit over all vector pairs into a Gram matrix
module gram_scheduler
  import gram_scheduler_pkg::*;
#(
  parameter int  M       = 4,
  parameter int  nBits   = 32,
  parameter int  LEN     = 100,
  parameter int  TIMEOUT = 1024,
  localparam int IDXW    = clog2(M),
  localparam int AW      = 2 * IDXW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             symmetric,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             ip_start,
  output logic [IDXW-1:0]  ip_selA,
  output logic [IDXW-1:0]  ip_selB,
  output logic [nBits-1:0] ip_maximumPos,
  output logic [nBits-1:0] ip_resetValue,
  output logic             ip_addSubs,
  input  logic             ip_endflag,
  input  logic [nBits-1:0] ip_result,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [nBits-1:0] wr_data
);

  localparam int TW = clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             sym_q, sym_d;
  logic             error_q, error_d;
  logic [nBits-1:0] res_q, res_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             cnt_clear;
  logic             cnt_advance;
  logic [IDXW-1:0]  idx_i;
  logic [IDXW-1:0]  idx_j;
  logic             idx_last;

  gram_index_counter #(
    .M    (M),
    .IDXW (IDXW)
  ) u_index (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .sym     (sym_q),
    .i       (idx_i),
    .j       (idx_j),
    .last    (idx_last)
  );

  assign ip_maximumPos = nBits'(LEN - 1);
  assign ip_resetValue = '0;
  assign ip_addSubs    = IP_ADD;
  assign ip_selA       = idx_i;
  assign ip_selB       = idx_j;
  assign wr_data       = res_q;
  assign error         = error_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_FIN);

  // M is a power of two, so row*M+col is a plain concatenation.
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    error_d     = error_q;
    res_d       = res_q;
    tmo_d       = tmo_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    ip_start    = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = {idx_i, idx_j};
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sym_d     = symmetric;
          error_d   = 1'b0;
          cnt_clear = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A flag still high from the previous product must drop before we issue.
        if (!ip_endflag) begin
          ip_start = 1'b1;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ip_endflag) begin
          res_d   = ip_result;
          state_d = ST_WRITE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_FIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = (sym_q && (idx_i != idx_j)) ? ST_MIRROR : ST_NEXT;
      end
      ST_MIRROR: begin
        wr_en   = 1'b1;
        wr_addr = {idx_j, idx_i};
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_last) begin
          state_d = ST_FIN;
        end else begin
          cnt_advance = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sym_q   <= 1'b0;
      error_q <= 1'b0;
      res_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      error_q <= error_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
